sprite_render: RTL
==================

Name: sprite_render

Overview:
- Sprite pixel back-end of the PPU; consumes the per-sprite stream from the sprite evaluation/OAM block.
- During sprite fetch (cycles 257-320) it loads up to 8 sprite slots with attribute, X, pattern low/high bytes and the sprite-0 tag.
- During the next line's visible cycles (1-256) it counts down X, shifts patterns out, and presents the winning sprite pixel to the pixel mux.

Parameters:
NSLOTS, 8, number of sprite slots; fixed by the fetch window of 64 cycles / 8 per sprite.

Ports:
clk  in  1  system clock (one PPU dot per cycle)
rst  in  1  synchronous active-high reset
rend  in  1  rendering enabled (bg or sprites on, visible/pre-render line)
cycle  in  9  current dot 0-340
ppumask  in  8  PPUMASK register; bit 4 = show sprites, bit 2 = show sprites in left 8 px
vram_data  in  8  pattern byte returned by VRAM, one cycle after address
attribute  in  8  current fetched sprite attribute; [7] vflip (handled upstream), [6] hflip, [5] priority, [1:0] palette
x  in  8  current fetched sprite X coordinate
sp_inscan  in  1  current fetched sprite is valid for the next line
sp0  in  1  OAM2 slot 0 holds sprite 0
sp_pix  out  2  winning sprite pattern pixel (0 = transparent)
sp_pal  out  2  winning sprite palette
sp_pri  out  1  winning sprite priority (1 = behind background)
sp_is0  out  1  winning opaque pixel belongs to sprite 0

Behaviour:
- Reset: all slot patterns 0, slot X counters 8'hff, slot valid 0; sp_pix, sp_pal, sp_pri, sp_is0 = 0.
- Load window, rend=1, cycle 257..320. Slot index s = (cycle-257)>>3; c8 = cycle[2:0].
  - c8==5: capture vram_data as pattern low.
  - c8==7: capture vram_data as pattern high; commit the slot.
  - Commit writes attribute[6] and x. attribute and x are stable from c8==5 and are latched at c8==7.
  - Commit writes valid = sp_inscan sampled at c8==7. If invalid, both pattern bytes are forced to 0.
  - hflip: both pattern bytes are bit-reversed at commit.
- sp0 is sampled at cycle 257 and tags slot 0 only (is0 = sp0). Slots 1-7 have is0 = 0.
- Render window, rend=1, cycle 1..256, px = cycle-1. Per slot, each cycle:
  - If xcnt != 0: decrement xcnt.
  - Else: the slot is active. Emit {hi[7], lo[7]} and shift both bytes left, filling with 0.
- A slot exhausts naturally after 8 shifts (pattern goes zero). X=255 gives at most 1 pixel. There is no wrap to the next line.
- Priority: the lowest slot index with an active, nonzero pixel wins. If there is no winner, sp_pix = 0 and the other outputs are 0.
- Masking: the output pixel is 0 if ppumask[4]==0, or if px<8 and ppumask[2]==0. Masked slots still shift, so timing is unaffected.
- Latency: outputs are registered. The values for px appear on the cycle after dot px+1, i.e. valid while cycle == px+2.
- Outside cycles 1..256, or rend=0: no shifting and no decrement; outputs driven 0 one cycle later.
  - Slots hold their contents when rend=0.
  - A load window with rend=0 commits nothing.
- Cycles 321-340 and 0: slots hold.
- Reset mid-line: immediate return to reset values; resumes at the next load window.
- Simultaneous events: load and render windows never overlap. If two slots are both opaque, the lower index wins regardless of its priority bit.

Decomposition:
- Shared package (ppudefs): PPUMASK_S=4 and PPUMASK_SL=2 bit indices; SPR_CYC_FETCH_START=257, SPR_CYC_FETCH_END=320; SPR_ATTR_HFLIP=6, SPR_ATTR_PRI=5.
- Sub-module sprite_slot, instantiated NSLOTS times. It holds the pattern shifters, xcnt, pal, pri, is0, and load/flip logic, and outputs its current 2-bit pixel.
- The top level holds the load sequencing, the priority mux and the output masking registers.

Test Plan:
- Slot 0 loaded with x=10, attr=8'h01, lo=8'h80, hi=8'h80 -> px 10: sp_pix=3, sp_pal=1; px 11-17: sp_pix=0.
- attr=8'h40 (hflip), lo=8'h01, hi=0, x=0, ppumask=8'h14 -> px 0: sp_pix=1; px 1-7: 0.
- Slots 0 and 1 both at x=20, lo=8'hff; slot1 attr=8'h02, slot0 attr=8'h21 -> px 20-27: sp_pal=1, sp_pri=1 (slot 0 wins).
- sp0=1 at cycle 257, slot 0 at x=3, lo=8'hff, ppumask=8'h10 -> px 0-7: sp_pix=0 (left clip); same with ppumask=8'h14 -> px 3: sp_is0=1.
- sp_inscan=0 for slot 2 with vram_data=8'hff -> slot 2 never contributes; all-slots-invalid line gives sp_pix=0 for px 0-255.
- rst asserted at cycle 100 mid-render -> next cycle all outputs 0; x=255, lo=8'h80 loaded next window -> only px 255 opaque.

Source files
------------

// File: rtl/sprite_render_pkg.sv
// ---------------------------------------------------------------------------
// ppudefs: shared PPU constants and types used by the sprite pixel back-end.
//   - PPUMASK bit indices, sprite attribute bit indices
//   - dot numbers bounding the sprite fetch, visible and left-clip windows
//   - spr_pix_t: one slot's candidate pixel with its tags
//   - bitrev8: horizontal flip helper
// ---------------------------------------------------------------------------
package ppudefs;

    localparam int NSLOTS         = 8;

    localparam int PPUMASK_S      = 4;
    localparam int PPUMASK_SL     = 2;
    localparam int SPR_ATTR_HFLIP = 6;
    localparam int SPR_ATTR_PRI   = 5;

    localparam logic [8:0] SPR_CYC_FETCH_START = 9'd257;
    localparam logic [8:0] SPR_CYC_FETCH_END   = 9'd320;
    localparam logic [8:0] SPR_CYC_VIS_START   = 9'd1;
    localparam logic [8:0] SPR_CYC_VIS_END     = 9'd256;
    // Last dot whose pixel (px = dot-1) falls inside the left 8-pixel column.
    localparam logic [8:0] SPR_CYC_CLIP_END    = 9'd8;

    typedef struct packed {
        logic       is0;
        logic       pri;
        logic [1:0] pal;
        logic [1:0] pix;
    } spr_pix_t;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

endpackage

// File: rtl/sprite_render_slot.sv
// ---------------------------------------------------------------------------
// sprite_slot: one sprite slot of the sprite pixel back-end.
// Holds the two pattern shifters, X down-counter and palette/priority/sprite-0
// tags. Pattern low is staged on i_ld_lo; i_commit captures pattern high and
// writes the whole slot (flipped if requested, zeroed if not in scanline).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_shift           render dot: decrement X or shift out a pixel
//   i_ld_lo           stage pattern low from i_vram_data
//   i_commit          capture pattern high and commit the slot
//   i_vram_data       pattern byte from VRAM
//   i_hflip, i_pri, i_pal, i_x, i_inscan, i_is0   slot contents at commit
//   o_pix             current candidate pixel (pix = 0 when transparent)
// ---------------------------------------------------------------------------
module sprite_slot
    import ppudefs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_shift,
    input  logic       i_ld_lo,
    input  logic       i_commit,
    input  logic [7:0] i_vram_data,
    input  logic       i_hflip,
    input  logic       i_pri,
    input  logic [1:0] i_pal,
    input  logic [7:0] i_x,
    input  logic       i_inscan,
    input  logic       i_is0,
    output spr_pix_t   o_pix
);

    logic [7:0] r_lo_stage;
    logic [7:0] r_lo;
    logic [7:0] r_hi;
    logic [7:0] r_xcnt;
    logic [1:0] r_pal;
    logic       r_pri;
    logic       r_is0;
    logic       r_valid;

    logic [7:0] w_lo_new;
    logic [7:0] w_hi_new;
    logic       w_active;

    assign w_lo_new = i_hflip ? bitrev8(r_lo_stage)  : r_lo_stage;
    assign w_hi_new = i_hflip ? bitrev8(i_vram_data) : i_vram_data;
    assign w_active = r_valid && (r_xcnt == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo_stage <= 8'h00;
            r_lo       <= 8'h00;
            r_hi       <= 8'h00;
            r_xcnt     <= 8'hff;
            r_pal      <= 2'b00;
            r_pri      <= 1'b0;
            r_is0      <= 1'b0;
            r_valid    <= 1'b0;
        end else if (i_commit) begin
            r_lo    <= i_inscan ? w_lo_new : 8'h00;
            r_hi    <= i_inscan ? w_hi_new : 8'h00;
            r_xcnt  <= i_x;
            r_pal   <= i_pal;
            r_pri   <= i_pri;
            r_is0   <= i_is0;
            r_valid <= i_inscan;
        end else if (i_ld_lo) begin
            r_lo_stage <= i_vram_data;
        end else if (i_shift) begin
            if (r_xcnt != 8'd0) begin
                r_xcnt <= r_xcnt - 8'd1;
            end else begin
                // Zero fill: after eight shifts the slot goes transparent.
                r_lo <= {r_lo[6:0], 1'b0};
                r_hi <= {r_hi[6:0], 1'b0};
            end
        end
    end

    assign o_pix.pix = w_active ? {r_hi[7], r_lo[7]} : 2'b00;
    assign o_pix.pal = r_pal;
    assign o_pix.pri = r_pri;
    assign o_pix.is0 = r_is0;

endmodule

// File: rtl/sprite_render.sv
// ---------------------------------------------------------------------------
// sprite_render: PPU sprite pixel back-end.
// Loads up to NSLOTS sprite slots during the sprite fetch window (dots
// 257-320) and, during the next line's visible dots (1-256), shifts them out
// and registers the winning sprite pixel for the pixel mux.
// Ports:
//   clk, rst          clock (one dot per cycle), synchronous active-high reset
//   rend              rendering enabled
//   cycle             current dot 0-340
//   ppumask           PPUMASK; bit 4 show sprites, bit 2 show left 8 px
//   vram_data         pattern byte from VRAM
//   attribute, x      current fetched sprite attribute / X
//   sp_inscan         current fetched sprite is valid for the next line
//   sp0               OAM2 slot 0 holds sprite 0 (sampled at dot 257)
//   sp_pix/pal/pri/is0  registered winning sprite pixel (valid at dot px+2)
// ---------------------------------------------------------------------------
module sprite_render
    import ppudefs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rend,
    input  logic [8:0] cycle,
    input  logic [7:0] ppumask,
    input  logic [7:0] vram_data,
    input  logic [7:0] attribute,
    input  logic [7:0] x,
    input  logic       sp_inscan,
    input  logic       sp0,
    output logic [1:0] sp_pix,
    output logic [1:0] sp_pal,
    output logic       sp_pri,
    output logic       sp_is0
);

    logic       w_render;
    logic       w_load;
    logic [2:0] w_slot;
    logic       w_ld_lo_cyc;
    logic       w_commit_cyc;
    logic       w_masked;
    logic       r_sp0;
    spr_pix_t   w_slot_pix [NSLOTS];
    spr_pix_t   w_win;
    logic       w_unused;

    assign w_render     = rend && (cycle >= SPR_CYC_VIS_START)   && (cycle <= SPR_CYC_VIS_END);
    assign w_load       = rend && (cycle >= SPR_CYC_FETCH_START) && (cycle <= SPR_CYC_FETCH_END);
    assign w_slot       = 3'((cycle - SPR_CYC_FETCH_START) >> 3);
    assign w_ld_lo_cyc  = w_load && (cycle[2:0] == 3'd5);
    assign w_commit_cyc = w_load && (cycle[2:0] == 3'd7);
    assign w_masked     = !ppumask[PPUMASK_S] ||
                          ((cycle <= SPR_CYC_CLIP_END) && !ppumask[PPUMASK_SL]);

    // Attribute bits 7 (vflip, applied upstream) and 4:2, plus unrelated
    // PPUMASK bits, are not needed here.
    assign w_unused = &{1'b0, attribute[7], attribute[4:2],
                        ppumask[7:5], ppumask[3], ppumask[1:0]};

    for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_slot
        sprite_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_shift     (w_render),
            .i_ld_lo     (w_ld_lo_cyc  && (w_slot == 3'(gi))),
            .i_commit    (w_commit_cyc && (w_slot == 3'(gi))),
            .i_vram_data (vram_data),
            .i_hflip     (attribute[SPR_ATTR_HFLIP]),
            .i_pri       (attribute[SPR_ATTR_PRI]),
            .i_pal       (attribute[1:0]),
            .i_x         (x),
            .i_inscan    (sp_inscan),
            .i_is0       (r_sp0 && (gi == 0)),
            .o_pix       (w_slot_pix[gi])
        );
    end

    // Walk from the highest index down so the lowest opaque slot wins,
    // independent of its priority bit.
    always_comb begin
        w_win = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (w_slot_pix[i].pix != 2'b00) w_win = w_slot_pix[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_pix <= 2'b00;
            sp_pal <= 2'b00;
            sp_pri <= 1'b0;
            sp_is0 <= 1'b0;
            r_sp0  <= 1'b0;
        end else begin
            if (w_render && !w_masked) begin
                {sp_is0, sp_pri, sp_pal, sp_pix} <= w_win;
            end else begin
                {sp_is0, sp_pri, sp_pal, sp_pix} <= 6'd0;
            end
            if (w_load && (cycle == SPR_CYC_FETCH_START)) r_sp0 <= sp0;
        end
    end

endmodule
